pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Output-side counterpart to the input debouncer. The debouncer cleans slow, noisy human input into clean single-clock signals. This block turns single-clock internal events into clean, human-visible output pulses of fixed length (LEDs, scope probes, board test points).
- Guarantees a minimum high time and a minimum low gap between pulses.
- Queues events that arrive while a pulse is in progress, so none are silently lost up to the queue limit.

Parameters:
- HOLD, 4: cycles the output is high per event; must be >= 1.
- GAP, 2: minimum low cycles between consecutive output pulses; must be >= 1.
- PEND_W, 2: width of the pending-event counter; up to 2^PEND_W-1 events are queued.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- trig  input  1  event strobe, sampled each posedge; every high cycle is one event.
- out  output  1  stretched pulse, registered.
- pending  output  PEND_W  queued events not yet emitted, registered.
- busy  output  1  high whenever state != IDLE, registered.
- overflow  output  1  sticky; set when an event is dropped because pending is saturated.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high, named reset. Reset has priority over trig.
- Reset values: out=0, pending=0, busy=0, overflow=0, state=IDLE, counter=0.
- State machine: IDLE, HOLD, GAP. A down-counter of width clog2(max(HOLD,GAP)+1) times HOLD and GAP.
- IDLE, trig=1 at edge t:
  - HOLD entered at t; counter loaded with HOLD-1; out=1 from edge t.
  - Latency from trig sample to out high is 0 edges (out changes on the same edge that samples trig).
- HOLD:
  - out=1 for exactly HOLD cycles.
  - When the counter reaches 0, the next edge enters GAP with counter=GAP-1 and out=0.
- GAP:
  - out=0 for exactly GAP cycles.
  - On the final edge (counter=0), if pending>0 or trig=1: enter HOLD, out=1. pending is decremented if it was nonzero and that pending event is consumed; otherwise the trig event is consumed.
  - Else return to IDLE.
- trig=1 while in HOLD or GAP (not consumed as described above): pending+1. If pending=2^PEND_W-1, the event is dropped, pending holds, and overflow is set.
- Simultaneous at the end of GAP, pending>0 and trig=1: the pending event is consumed and trig is queued; pending is unchanged (net 0). No overflow in this case.
- Back-to-back period is HOLD+GAP cycles. out is never high for more than HOLD consecutive cycles. out is never low for fewer than GAP cycles between pulses.
- overflow clears only on reset.
- Reset mid-HOLD or mid-GAP: next edge out=0, queue flushed, state IDLE.

Test Plan (HOLD=4, GAP=2, PEND_W=2):
- reset=1 for 2 cycles, trig=1 -> out=0, pending=0, busy=0, overflow=0 throughout.
- Single 1-cycle trig at edge t -> out=1 after edges t..t+3, out=0 from t+4. busy=1 from t through t+5, 0 from t+6.
- trig at t and at t+2 -> pending=1 after t+2. Second pulse: out=1 after t+6..t+9, low from t+10. pending=0 after t+6.
- trig held high 6 cycles starting at t -> pending saturates at 3 after t+3; overflow=1 after t+4 and stays set. Exactly 4 pulses are emitted, period 6 cycles.
- pending=1 and trig=1 on the final GAP edge -> out rises on that edge and pending stays 1.
- reset asserted after edge t+2 of a pulse with pending=2 -> next edge out=0, pending=0, busy=0. A subsequent trig starts a fresh 4-cycle pulse.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-length output pulses with a guaranteed
// low gap between them. Events that arrive mid-pulse are queued in a saturating counter.
module pulse_stretcher #(
  parameter int unsigned HOLD   = 4,
  parameter int unsigned GAP    = 2,
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  output logic              out,
  output logic [PEND_W-1:0] pending,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned MAX_CNT = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               out_q, out_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               enq;
  logic               deq;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, queue bookkeeping and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    enq     = 1'b0;
    deq     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        enq = trig;
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          enq   = trig;
          cnt_d = cnt_q - CNT_W'(1);
        end else if (pend_q != '0) begin
          // Oldest queued event wins; a coincident strobe takes its place in the queue.
          deq     = 1'b1;
          enq     = trig;
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end else if (trig) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (deq && !enq) begin
      pend_d = pend_q - PEND_W'(1);
    end else if (enq && !deq) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end

    out_d  = (state_d == S_HOLD);
    busy_d = (state_d != S_IDLE);
  end

  assign out      = out_q;
  assign pending  = pend_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed vector table, hand-written corner sequences and
// random strobes checked against a timeline model of the pulse train.
module tb_pulse_stretcher;

  localparam int unsigned HOLD   = 4;
  localparam int unsigned GAP    = 2;
  localparam int unsigned PEND_W = 2;
  localparam int          QMAX   = (1 << PEND_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              trig;
  logic              out;
  logic [PEND_W-1:0] pending;
  logic              busy;
  logic              overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: a pulse train described by the edge at which the current pulse started.
  int m_active = 0;
  int m_start  = 0;
  int m_q      = 0;
  int m_ovf    = 0;

  typedef struct {
    logic rst;
    logic trg;
    logic e_out;
    int   e_pend;
    logic e_busy;
    logic e_ovf;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pulse_stretcher #(.HOLD(HOLD), .GAP(GAP), .PEND_W(PEND_W)) dut (
    .clk(clk), .reset(reset), .trig(trig), .out(out),
    .pending(pending), .busy(busy), .overflow(overflow)
  );

  task automatic addn(input int n, input logic r, input logic t, input logic o,
                      input int p, input logic b, input logic v);
    for (int i = 0; i < n; i++) vecs.push_back('{r, t, o, p, b, v});
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eo, input int ep, input int eb,
                         input int ev);
    chk({tag, ".out"}, int'(out), eo);
    chk({tag, ".pending"}, int'(pending), ep);
    chk({tag, ".busy"}, int'(busy), eb);
    chk({tag, ".overflow"}, int'(overflow), ev);
  endtask

  task automatic model_edge(input logic r, input logic t);
    int rel;
    if (r) begin
      m_active = 0; m_q = 0; m_ovf = 0;
    end else if (m_active == 0) begin
      if (t) begin m_active = 1; m_start = cyc; end
    end else begin
      rel = cyc - m_start;
      if (rel >= HOLD + GAP) begin
        if (m_q > 0) begin
          m_start = cyc;
          if (!t) m_q--;
        end else if (t) begin
          m_start = cyc;
        end else begin
          m_active = 0;
        end
      end else if (t) begin
        if (m_q == QMAX) m_ovf = 1;
        else m_q++;
      end
    end
  endtask

  function automatic int model_out();
    return (m_active != 0 && (cyc - m_start) < HOLD) ? 1 : 0;
  endfunction

  // One clock: drive, let the edge happen, advance the model, sample #1 later.
  task automatic tick(input logic r, input logic t);
    reset = r;
    trig  = t;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(r, t);
  endtask

  initial begin
    int rises[$];
    int prev_out;
    int density;

    reset = 1'b1;
    trig  = 1'b0;

    // Reset with trig high, then a single 1-cycle strobe.
    addn(2, 1, 1, 0, 0, 0, 0);
    addn(1, 0, 1, 1, 0, 1, 0);
    addn(3, 0, 0, 1, 0, 1, 0);
    addn(2, 0, 0, 0, 0, 1, 0);
    addn(2, 0, 0, 0, 0, 0, 0);
    // Strobes at t and t+2: second pulse queued behind the first.
    addn(1, 0, 1, 1, 0, 1, 0);
    addn(1, 0, 0, 1, 0, 1, 0);
    addn(1, 0, 1, 1, 1, 1, 0);
    addn(1, 0, 0, 1, 1, 1, 0);
    addn(2, 0, 0, 0, 1, 1, 0);
    addn(4, 0, 0, 1, 0, 1, 0);
    addn(2, 0, 0, 0, 0, 1, 0);
    addn(1, 0, 0, 0, 0, 0, 0);
    // Strobe coinciding with the final gap edge while one event is queued.
    addn(1, 0, 1, 1, 0, 1, 0);
    addn(1, 0, 1, 1, 1, 1, 0);
    addn(2, 0, 0, 1, 1, 1, 0);
    addn(2, 0, 0, 0, 1, 1, 0);
    addn(1, 0, 1, 1, 1, 1, 0);
    addn(3, 0, 0, 1, 1, 1, 0);
    addn(2, 0, 0, 0, 1, 1, 0);
    addn(4, 0, 0, 1, 0, 1, 0);
    addn(2, 0, 0, 0, 0, 1, 0);
    addn(1, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].trg);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].e_out), vecs[i].e_pend,
              int'(vecs[i].e_busy), int'(vecs[i].e_ovf));
    end

    // Trig held for 6 cycles: queue saturates, overflow sticks, exactly 4 pulses.
    prev_out = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1);
      chk($sformatf("sat.pending%0d", i), int'(pending), (i < QMAX) ? i : QMAX);
      chk($sformatf("sat.overflow%0d", i), int'(overflow), (i >= 4) ? 1 : 0);
      if (out && prev_out == 0) rises.push_back(i);
      prev_out = int'(out);
    end
    for (int i = 6; i < 36; i++) begin
      tick(1'b0, 1'b0);
      if (out && prev_out == 0) rises.push_back(i);
      prev_out = int'(out);
    end
    chk("sat.pulse_count", rises.size(), 4);
    for (int i = 1; i < rises.size(); i++)
      chk($sformatf("sat.period%0d", i), rises[i] - rises[i-1], HOLD + GAP);
    chk_all("sat.end", 0, 0, 0, 1);

    tick(1'b1, 1'b0);
    chk_all("sat.reset", 0, 0, 0, 0);

    // Reset in the middle of a pulse with two events queued.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk_all("midrst.pre", 1, 2, 1, 0);
    tick(1'b1, 1'b0);
    chk_all("midrst.post", 0, 0, 0, 0);
    tick(1'b0, 1'b1);
    chk_all("midrst.fresh0", 1, 0, 1, 0);
    for (int i = 1; i < HOLD; i++) begin
      tick(1'b0, 1'b0);
      chk($sformatf("midrst.fresh%0d", i), int'(out), 1);
    end
    tick(1'b0, 1'b0);
    chk_all("midrst.low", 0, 0, 1, 0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk_all("midrst.idle", 0, 0, 0, 0);

    // Random strobes with varying density and rare resets, against the model.
    tick(1'b1, 1'b0);
    density = 30;
    for (int i = 0; i < 3000; i++) begin
      logic r, t;
      if (i % 250 == 0) density = $urandom_range(5, 90);
      r = ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 99) < density);
      tick(r, t);
      chk_all("rand", model_out(), m_q, m_active, m_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
